// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - frame constants, complex sample type and bit-reverse helper for the FFT reorder buffer
package fft_pkg;

  localparam int LOG2N = 5;
  localparam int N     = 2 ** LOG2N;
  localparam int DW    = 16;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } cplx_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = idx[LOG2N-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/bitrev_pp_ram.sv
// rtl/bitrev_pp_ram.sv - two-bank sample store, one write port and one registered read port
module bitrev_pp_ram
  import fft_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic [LOG2N-1:0] wr_addr,
  input  cplx_t            wr_data,
  input  logic             rd_en,
  input  logic             rd_bank,
  input  logic [LOG2N-1:0] rd_addr,
  output cplx_t            rd_data
);

  cplx_t mem [2*N];
  cplx_t rd_data_q;
  cplx_t rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_bank, wr_addr}] <= wr_data;
    end
  end

  // Read register holds its value between read beats so the output data is stable across stalls.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem[{rd_bank, rd_addr}];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fft_bitrev_buf.sv
// rtl/fft_bitrev_buf.sv - ping-pong bit-reversal reorder buffer; FFT_BITREV_SYNC_CHK_EN adds the frame-index check
module fft_bitrev_buf #(
  parameter int DW    = 16,
  parameter int LOG2N = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [LOG2N-1:0] cnt_ctrl,
  input  logic [DW-1:0]    din_re,
  input  logic [DW-1:0]    din_im,
  output logic             dout_valid,
  output logic [DW-1:0]    dout_re,
  output logic [DW-1:0]    dout_im,
  output logic             dout_sof,
  output logic             dout_eof,
  output logic             sync_err
);

  import fft_pkg::*;

  localparam logic STATE_FILL   = 1'b0;
  localparam logic STATE_STREAM = 1'b1;
  localparam logic [LOG2N-1:0] IDX_LAST = '1;

  logic  state_q, state_d;
  logic  wr_bank_q, wr_bank_d;
  logic  dout_valid_q, dout_valid_d;
  logic  dout_sof_q, dout_sof_d;
  logic  dout_eof_q, dout_eof_d;
  logic  rd_en;
  logic  last_beat;
  cplx_t wr_data;
  cplx_t rd_data;

  assign last_beat = valid && (cnt_ctrl == IDX_LAST);
  assign rd_en     = valid && (state_q == STATE_STREAM);
  assign wr_data   = {din_re, din_im};

  // Reads always target the bank not being written; the toggle on the last beat only affects the next beat.
  bitrev_pp_ram u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (valid),
    .wr_bank (wr_bank_q),
    .wr_addr (cnt_ctrl),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_bank (~wr_bank_q),
    .rd_addr (bitrev(cnt_ctrl)),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d      = state_q;
    wr_bank_d    = wr_bank_q;
    dout_valid_d = rd_en;
    dout_sof_d   = rd_en && (cnt_ctrl == '0);
    dout_eof_d   = rd_en && (cnt_ctrl == IDX_LAST);
    if (last_beat) begin
      wr_bank_d = ~wr_bank_q;
      state_d   = STATE_STREAM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= STATE_FILL;
      wr_bank_q    <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_sof_q   <= 1'b0;
      dout_eof_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_bank_q    <= wr_bank_d;
      dout_valid_q <= dout_valid_d;
      dout_sof_q   <= dout_sof_d;
      dout_eof_q   <= dout_eof_d;
    end
  end

  assign dout_valid = dout_valid_q;
  assign dout_sof   = dout_sof_q;
  assign dout_eof   = dout_eof_q;
  assign dout_re    = rd_data.re;
  assign dout_im    = rd_data.im;

`ifdef FFT_BITREV_SYNC_CHK_EN
  logic [LOG2N-1:0] exp_idx_q, exp_idx_d;
  logic             sync_err_q, sync_err_d;

  // After a mismatch the expectation re-locks to the observed index so only the first slip is flagged.
  always_comb begin
    exp_idx_d  = exp_idx_q;
    sync_err_d = sync_err_q;
    if (valid) begin
      if (cnt_ctrl != exp_idx_q) begin
        sync_err_d = 1'b1;
        exp_idx_d  = cnt_ctrl + 1'b1;
      end else begin
        exp_idx_d  = exp_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_idx_q  <= '0;
      sync_err_q <= 1'b0;
    end else begin
      exp_idx_q  <= exp_idx_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign sync_err = sync_err_q;
`else
  assign sync_err = 1'b0;
`endif

endmodule

// File: doc/fft_bitrev_buf.md
Name: fft_bitrev_buf

Overview:
Output reorder buffer placed directly downstream of the 5-bit frame-index counter (cnt_ctrl) in the 32-point FFT datapath. Captures FFT output samples in natural index order and replays each completed frame in bit-reversed index order.
Uses a ping-pong pair of banks, so one frame is written while the previous frame is read. Output cadence follows the input valid cadence exactly.

Parameters:
DW, 16, bit width of each real and imaginary sample component
LOG2N, 5, log2 of the frame length; N = 2**LOG2N = 32; must match the counter width

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
valid  input  1  input sample strobe; same strobe that advances cnt_ctrl
cnt_ctrl  input  LOG2N  frame index of the current input sample (0..N-1)
din_re  input  DW  input sample, real part
din_im  input  DW  input sample, imaginary part
dout_valid  output  1  output sample strobe
dout_re  output  DW  reordered sample, real part
dout_im  output  DW  reordered sample, imaginary part
dout_sof  output  1  qualifies the first sample of an output frame
dout_eof  output  1  qualifies the last sample of an output frame
sync_err  output  1  sticky index-mismatch flag (see Optional Feature)

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all outputs 0; wr_bank=0; state=FILL; internal expected index exp_idx=0.
- States:
  - FILL: no output yet.
  - STREAM: reading the completed bank.
  - FILL->STREAM on the valid beat with cnt_ctrl==N-1.
  - STREAM persists until rst. No other transitions.
- Write path:
  - On valid, bank[wr_bank][cnt_ctrl] <= {din_re, din_im}.
  - On valid with cnt_ctrl==N-1, wr_bank toggles at the same edge.
- Read path (STREAM only):
  - On valid, read bank[~wr_bank][bitrev(cnt_ctrl)].
  - bitrev reverses all LOG2N bits, e.g. 1->16, 3->24.
- Output register:
  - Read data is registered, so dout_* appear 1 cycle after the valid beat that addressed them.
  - dout_valid = registered (valid && state==STREAM).
  - dout_sof = registered (read beat with cnt_ctrl==0).
  - dout_eof = registered (read beat with cnt_ctrl==N-1).
  - dout_re/dout_im hold their last value when dout_valid=0.
- Frame latency:
  - Sample k of frame F emerges during frame F+1.
  - First dout_valid occurs 1 cycle after the first valid beat of frame 2 (cnt_ctrl=0).
- Stall: valid=0 means no write, no read, no wr_bank change, dout_valid=0 next cycle. A gap of any length mid-frame is legal.
- Simultaneous read/write: always target opposite banks. The bank toggle on cnt_ctrl==N-1 takes effect for the next beat, so the final read of a frame still uses the old ~wr_bank.
- cnt_ctrl wrap (N-1 -> 0) is the only frame delimiter. No separate start signal.
- Reset mid-frame: partial frame discarded, return to FILL, output immediately 0.
- Memory: 2*N entries of 2*DW bits. No read-before-write hazard, because bank separation is guaranteed.

Optional Feature:
- Macro: FFT_BITREV_SYNC_CHK_EN.
- Defined:
  - exp_idx increments modulo N on each valid beat and reloads to cnt_ctrl+1 after a mismatch.
  - sync_err sets (sticky) when valid && cnt_ctrl != exp_idx; cleared only by rst.
  - Data path is unaffected.
- Undefined: exp_idx logic removed; sync_err tied to 0. The port is always present.

Decomposition:
- Package fft_pkg:
  - LOG2N and N constants.
  - DW default.
  - typedef cplx_t packed struct {re, im} of DW bits each.
  - Function bitrev(idx) of LOG2N bits.
- Sub-module bitrev_pp_ram: dual-bank storage with one write port and one registered read port, bank-select input, cplx_t data.
- Top module fft_bitrev_buf holds the FSM, bank toggle, flags, and sync check.

Test Plan:
- Two back-to-back frames, din_re=k, din_im=100+k, valid continuous:
  - No dout_valid during frame 1.
  - Frame 2 output din_re sequence = 0,16,8,24,4,20,12,28,2,...,31.
  - dout_im = 100 + same indices.
  - dout_sof on the first beat, dout_eof on the 32nd.
- Latency check: first dout_valid rises exactly 1 cycle after the valid beat with cnt_ctrl=0 of frame 2.
- Stall: drop valid for 3 cycles at cnt_ctrl=10 in frame 2 -> dout_valid low for 3 cycles, sequence resumes unchanged, no sample lost or repeated.
- Reset: assert rst at cnt_ctrl=20 of frame 3 -> outputs 0 asynchronously; after release, 32 beats with no output, then correct reordering of the new frame.
- Sync check (macro defined): skip cnt_ctrl 7->9 on consecutive valid beats -> sync_err=1 the next cycle, stays 1 until rst. With the macro undefined, sync_err stays 0.
- Continuous 4 frames with random data: scoreboard compares against software bitrev of the previous frame; zero mismatches.
